distributive_checker: RTL and testbench
=======================================

Name: distributive_checker

Overview:
Registered datapath that evaluates both sides of the Boolean distributive law, s0 = x | (y & z) and s1 = (x | y) & (x | z), on WIDTH-bit bitwise operands, and flags any disagreement. The checker has two operating modes. In external mode, operands come from the ports. In sweep mode, an internal generator walks all 8 single-bit combinations, ordered x,y,z = 000..111. It is a self-checking leaf used in logic-gate bring-up and as a regression canary for gate primitives.

Parameters:
WIDTH, 1, bit width of x, y, z, s0, s1; all operations are bitwise.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
x  in  WIDTH  operand x (external mode)
y  in  WIDTH  operand y (external mode)
z  in  WIDTH  operand z (external mode)
in_valid  in  1  external operands valid this cycle
start  in  1  single-cycle pulse that begins an 8-step sweep
s0  out  WIDTH  registered x | (y & z)
s1  out  WIDTH  registered (x | y) & (x | z)
out_valid  out  1  s0/s1/mismatch valid this cycle
mismatch  out  1  registered (s0 != s1), qualified by out_valid
busy  out  1  sweep in progress
done  out  1  one-cycle pulse after the last sweep step registers
pass_count  out  4  sweep steps with s0 == s1 (0..8)
fail_count  out  4  sweep steps with s0 != s1 (0..8)

Behaviour:
- Reset (rst=1 at a clk edge) clears every output to 0 and returns the FSM to IDLE. A reset asserted mid-sweep aborts the sweep; no done pulse is produced.
- FSM has two states, IDLE and SWEEP.
- IDLE:
  - in_valid=1 captures x,y,z. One clock later, s0/s1/mismatch update and out_valid=1.
  - Latency is exactly 1 cycle. Back-to-back in_valid gives full throughput.
  - If in_valid=0, out_valid is 0 the next cycle and s0/s1 hold their last values.
- IDLE + start=1:
  - Enter SWEEP and clear pass_count/fail_count.
  - start takes priority over in_valid in the same cycle; in_valid is dropped.
- SWEEP:
  - 3-bit step counter k runs 0..7, one step per cycle. Operands are x=k[2], y=k[1], z=k[0], each replicated to WIDTH bits.
  - in_valid and start are ignored while busy=1.
  - Each step produces out_valid=1 one cycle later and increments pass_count or fail_count.
  - After step 7 registers, done=1 for one cycle, busy drops, and the FSM returns to IDLE.
  - busy is high from the cycle after start through the final step's output cycle (8 cycles).
- Counters hold their values after done until the next start or reset. A correct implementation always ends a sweep with pass_count=8 and fail_count=0.
- No overflow is possible: the 4-bit counters hold a maximum of 8.
- Golden sweep sequence, s0 for k=0..7: 0,0,0,1,1,1,1,1. s1 is identical.

Decomposition:
- Shared package distributive_pkg holds:
  - the FSM state enum (IDLE, SWEEP)
  - SWEEP_STEPS = 8
  - COUNT_W = 4
- One natural sub-module, gate2_bitwise: parameterized WIDTH and OP (AND/OR), purely combinational, instantiated 5 times.
  - s0 path: one AND feeding one OR.
  - s1 path: two ORs feeding one AND.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> all outputs 0, busy=0.
- External mode, WIDTH=1: apply each of the 8 vectors 000..111 with in_valid=1 back-to-back -> next-cycle s0=s1 = 0,0,0,1,1,1,1,1 respectively; mismatch=0; out_valid high for 8 cycles.
- External mode, WIDTH=8: x=8'hF0, y=8'hCC, z=8'hAA with in_valid=1 -> s0=s1=8'hF8 one cycle later, mismatch=0.
- Sweep: start pulse -> busy for 8 cycles; s0 sequence 0,0,0,1,1,1,1,1; then a single done pulse with pass_count=8, fail_count=0.
- Priority and ignore: start together with in_valid (x=1) -> the sweep runs and the external operand is dropped; in_valid and start asserted during the sweep -> ignored, counts still 8/0.
- Reset mid-sweep: rst at step 4 -> next cycle busy=0, counters 0, no done pulse; a new start then completes normally with 8/0.

Source files
------------

// File: rtl/distributive_pkg.sv
// Shared types and constants for the distributive-law checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package distributive_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_OR  = 1'b1
  } gate_op_t;

  localparam int SWEEP_STEPS = 8;
  localparam int COUNT_W     = 4;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/gate2_bitwise.sv
// Two-input bitwise gate, AND or OR selected at elaboration time.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
module gate2_bitwise
  import distributive_pkg::*;
#(
  parameter int       WIDTH = 1,
  parameter gate_op_t OP    = OP_AND
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (OP == OP_AND) ? (a & b) : (a | b);

endmodule

// File: rtl/distributive_checker.sv
// Evaluates x|(y&z) and (x|y)&(x|z) from ports or an 8-step sweep; flags disagreement.
// Latency: one cycle from accepted operands to s0/s1/mismatch/out_valid.
// Backpressure: none; in_valid/start are dropped while a sweep is busy.
module distributive_checker
  import distributive_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             in_valid,
  input  logic             start,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic             out_valid,
  output logic             mismatch,
  output logic             busy,
  output logic             done,
  output logic [COUNT_W-1:0] pass_count,
  output logic [COUNT_W-1:0] fail_count
);

  localparam logic [2:0] LAST_K = 3'(SWEEP_STEPS - 1);

  state_t     state_q, state_d;
  logic [2:0] k_q;
  logic       last_q;
  logic       sweep_step, ext_step, start_acc;

  logic [WIDTH-1:0] op_x, op_y, op_z;
  logic [WIDTH-1:0] yz_and, s0_comb;
  logic [WIDTH-1:0] xy_or, xz_or, s1_comb;
  logic             eq;

  // Sweep operands come from the step counter, replicated across the word.
  assign op_x = sweep_step ? {WIDTH{k_q[2]}} : x;
  assign op_y = sweep_step ? {WIDTH{k_q[1]}} : y;
  assign op_z = sweep_step ? {WIDTH{k_q[0]}} : z;

  gate2_bitwise #(.WIDTH(WIDTH), .OP(OP_AND)) u_s0_and (.a(op_y), .b(op_z),   .y(yz_and));
  gate2_bitwise #(.WIDTH(WIDTH), .OP(OP_OR))  u_s0_or  (.a(op_x), .b(yz_and), .y(s0_comb));
  gate2_bitwise #(.WIDTH(WIDTH), .OP(OP_OR))  u_s1_or0 (.a(op_x), .b(op_y),   .y(xy_or));
  gate2_bitwise #(.WIDTH(WIDTH), .OP(OP_OR))  u_s1_or1 (.a(op_x), .b(op_z),   .y(xz_or));
  gate2_bitwise #(.WIDTH(WIDTH), .OP(OP_AND)) u_s1_and (.a(xy_or), .b(xz_or), .y(s1_comb));

  assign eq = (s0_comb == s1_comb);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and step qualifiers; busy also covers the final output cycle
  // after the FSM is already back in IDLE, so inputs are gated on it.
  always_comb begin
    state_d    = state_q;
    sweep_step = 1'b0;
    ext_step   = 1'b0;
    start_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!busy) begin
          if (start) begin
            start_acc  = 1'b1;
            sweep_step = 1'b1;
            state_d    = SWEEP;
          end else if (in_valid) begin
            ext_step = 1'b1;
          end
        end
      end
      SWEEP: begin
        sweep_step = 1'b1;
        if (k_q == LAST_K) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Step counter wraps to 0 after step 7, ready for the next start.
  always_ff @(posedge clk) begin
    if (rst)             k_q <= '0;
    else if (sweep_step) k_q <= k_q + 3'd1;
  end

  // Result registers; s0/s1 hold when nothing was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0        <= '0;
      s1        <= '0;
      out_valid <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      out_valid <= sweep_step | ext_step;
      mismatch  <= (sweep_step | ext_step) & ~eq;
      if (sweep_step | ext_step) begin
        s0 <= s0_comb;
        s1 <= s1_comb;
      end
    end
  end

  // Sweep status: busy tracks step outputs, done follows the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      last_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy   <= sweep_step;
      last_q <= sweep_step && (k_q == LAST_K);
      done   <= last_q;
    end
  end

  // Pass/fail tallies restart with the first step's result on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (start_acc) begin
      pass_count <= COUNT_W'(eq);
      fail_count <= COUNT_W'(~eq);
    end else if (sweep_step) begin
      pass_count <= pass_count + COUNT_W'(eq);
      fail_count <= fail_count + COUNT_W'(~eq);
    end
  end

endmodule

// File: tb/tb_distributive_checker.sv
module tb_distributive_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] x1, y1, z1;
  logic       in_valid1, start1;
  logic [0:0] s0_1, s1_1;
  logic       out_valid1, mismatch1, busy1, done1;
  logic [3:0] pass1, fail1;

  logic [7:0] x8, y8, z8;
  logic       in_valid8, start8;
  logic [7:0] s0_8, s1_8;
  logic       out_valid8, mismatch8, busy8, done8;
  logic [3:0] pass8, fail8;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] golden = 8'b1111_1000;

  always #5 clk = ~clk;

  distributive_checker #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .z(z1),
    .in_valid(in_valid1), .start(start1),
    .s0(s0_1), .s1(s1_1), .out_valid(out_valid1), .mismatch(mismatch1),
    .busy(busy1), .done(done1), .pass_count(pass1), .fail_count(fail1)
  );

  distributive_checker #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .z(z8),
    .in_valid(in_valid8), .start(start8),
    .s0(s0_8), .s1(s1_8), .out_valid(out_valid8), .mismatch(mismatch8),
    .busy(busy8), .done(done8), .pass_count(pass8), .fail_count(fail8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a sweep and follow it through done; noise drives in_valid/start
  // with x=1 during the sweep, which must have no effect.
  task automatic run_sweep(input bit noise);
    start1 = 1'b1; in_valid1 = noise; x1 = noise; y1 = 1'b0; z1 = 1'b0;
    tick();
    start1 = 1'b0; in_valid1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("sweep_busy", busy1, 1);
      check("sweep_valid", out_valid1, 1);
      check("sweep_s0", s0_1, golden[c]);
      check("sweep_s1", s1_1, golden[c]);
      check("sweep_mismatch", mismatch1, 0);
      check("sweep_done_early", done1, 0);
      check("sweep_pass_run", pass1, c + 1);
      start1 = noise; in_valid1 = noise; x1 = noise;
      tick();
    end
    start1 = 1'b0; in_valid1 = 1'b0; x1 = 1'b0;
    check("done_pulse", done1, 1);
    check("done_busy", busy1, 0);
    check("done_valid", out_valid1, 0);
    check("done_pass", pass1, 8);
    check("done_fail", fail1, 0);
    tick();
    check("done_single", done1, 0);
    check("hold_pass", pass1, 8);
    check("hold_fail", fail1, 0);
  endtask

  initial begin
    rst = 1'b1;
    x1 = 1'($urandom); y1 = 1'($urandom); z1 = 1'($urandom);
    in_valid1 = 1'($urandom); start1 = 1'($urandom);
    x8 = 8'($urandom); y8 = 8'($urandom); z8 = 8'($urandom);
    in_valid8 = 1'($urandom); start8 = 1'($urandom);
    tick();
    tick();
    check("rst_s0", s0_1, 0);
    check("rst_s1", s1_1, 0);
    check("rst_valid", out_valid1, 0);
    check("rst_mismatch", mismatch1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_fail", fail1, 0);
    check("rst_s0_w8", s0_8, 0);
    check("rst_busy_w8", busy8, 0);

    rst = 1'b0; start1 = 1'b0; in_valid1 = 1'b0; start8 = 1'b0; in_valid8 = 1'b0;
    tick();

    // External mode, all eight single-bit vectors back to back.
    for (int i = 0; i < 8; i++) begin
      x1 = 1'(i >> 2); y1 = 1'(i >> 1); z1 = 1'(i);
      in_valid1 = 1'b1;
      tick();
      check("ext_valid", out_valid1, 1);
      check("ext_s0", s0_1, golden[i]);
      check("ext_s1", s1_1, golden[i]);
      check("ext_mismatch", mismatch1, 0);
    end
    in_valid1 = 1'b0; x1 = 1'b0; y1 = 1'b0; z1 = 1'b0;
    tick();
    check("idle_valid", out_valid1, 0);
    check("idle_hold_s0", s0_1, 1);
    check("idle_hold_s1", s1_1, 1);
    check("idle_busy", busy1, 0);

    // External mode, 8-bit word.
    x8 = 8'hF0; y8 = 8'hCC; z8 = 8'hAA; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    check("w8_valid", out_valid8, 1);
    check("w8_s0", s0_8, 8'hF8);
    check("w8_s1", s1_8, 8'hF8);
    check("w8_mismatch", mismatch8, 0);
    tick();
    check("w8_valid_drop", out_valid8, 0);
    check("w8_hold_s0", s0_8, 8'hF8);

    // Plain sweep.
    run_sweep(1'b0);

    // Start with in_valid in the same cycle, then noise during the sweep.
    run_sweep(1'b1);

    // Reset while step 4 is being applied.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c < 4; c++) tick();
    check("pre_abort_busy", busy1, 1);
    check("pre_abort_pass", pass1, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_pass", pass1, 0);
    check("abort_fail", fail1, 0);
    check("abort_valid", out_valid1, 0);
    for (int c = 0; c < 10; c++) begin
      check("abort_no_done", done1, 0);
      check("abort_idle", busy1, 0);
      tick();
    end

    run_sweep(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
